// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard controller: FSM encoding, shadow-pipeline
// entry layout and default pipeline geometry.
package id_hazard_ctrl_pkg;

  localparam int unsigned DEF_FWD_STG = 2;
  localparam int unsigned DEF_MC_LAT  = 3;
  localparam int unsigned SHD_AW      = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_HALT    = 2'd2
  } hz_state_e;

  // One in-flight instruction as seen by the hazard logic; dst is zero-extended.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [SHD_AW-1:0] dst;
    logic              load;
    logic              hlt;
  } shd_ent_t;

  localparam shd_ent_t SHD_BUBBLE = '0;

endpackage

// File: rtl/id_fwd_match.sv
// Per-read-port comparator: youngest matching producer among the shadow stages,
// plus a flag for a load still in stage 0 (load-use hazard).
module id_fwd_match
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned FWD_STG = DEF_FWD_STG
) (
  input  logic                     re,
  input  logic [REG_AW-1:0]        addr,
  input  shd_ent_t [FWD_STG-1:0]   stg,
  output logic [FWD_STG-1:0]       sel_c,
  output logic                     load_hit_c
);

  logic [FWD_STG-1:0] hit;
  logic [FWD_STG-1:0] unused_hlt;

  always_comb begin
    sel_c      = '0;
    load_hit_c = 1'b0;
    hit        = '0;
    unused_hlt = '0;
    for (int k = 0; k < FWD_STG; k++) begin
      unused_hlt[k] = stg[k].hlt;
      hit[k] = re && (addr != '0) && stg[k].valid && stg[k].we &&
               (stg[k].dst == SHD_AW'(addr));
    end
    load_hit_c = hit[0] && stg[0].load;
    // Walk oldest to youngest so the youngest producer overwrites older ones.
    for (int k = FWD_STG - 1; k >= 0; k--) begin
      if (hit[k] && !(k == 0 && stg[k].load)) begin
        sel_c    = '0;
        sel_c[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: shadow pipeline of in-flight writers, load-use
// stall, multi-cycle EX hold, flush squashing, HLT handling and bypass selects.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned FWD_STG     = DEF_FWD_STG,
  parameter int unsigned MC_LAT      = DEF_MC_LAT,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_RD-1:0]           id_re,
  input  logic [NUM_RD*REG_AW-1:0]    id_rd_addr,
  input  logic                        id_we,
  input  logic [REG_AW-1:0]           id_dst,
  input  logic                        id_load,
  input  logic                        id_mc,
  input  logic                        id_hlt,
  input  logic                        flow_change,
  output logic                        stall_if,
  output logic                        bubble_ex,
  output logic                        hold_ex,
  output logic [NUM_RD*FWD_STG-1:0]   byp_sel,
  output logic                        halted
);

  localparam int unsigned MC_W = 4;
  localparam int unsigned FL_W = 2;

  hz_state_e                   fsm_q, fsm_d;
  logic [MC_W-1:0]             mc_cnt_q, mc_cnt_d;
  logic [FL_W-1:0]             flush_cnt_q, flush_cnt_d;
  shd_ent_t [FWD_STG-1:0]      stg_q, stg_d;
  logic [NUM_RD*FWD_STG-1:0]   byp_q, byp_d;
  logic                        halted_q, halted_d;

  logic [FWD_STG-1:0]          sel [NUM_RD];
  logic [NUM_RD-1:0]           ld_hit;
  logic                        squash, busy, halt_st, load_use, stall, issue;
  shd_ent_t                    ent_new;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    id_fwd_match #(
      .REG_AW  (REG_AW),
      .FWD_STG (FWD_STG)
    ) u_match (
      .re         (id_re[p]),
      .addr       (id_rd_addr[p*REG_AW +: REG_AW]),
      .stg        (stg_q),
      .sel_c      (sel[p]),
      .load_hit_c (ld_hit[p])
    );
  end

  // Hazard decisions; squash outranks every stall source.
  always_comb begin
    squash   = flow_change || (flush_cnt_q != '0);
    busy     = (fsm_q == ST_MC_BUSY);
    halt_st  = (fsm_q == ST_HALT);
    load_use = id_valid && (|ld_hit);
    stall    = !squash && (halt_st || busy || load_use);
    issue    = id_valid && !stall && !squash && !busy && !halt_st;
  end

  assign stall_if  = !rst && stall;
  assign hold_ex   = !rst && busy;
  assign bubble_ex = !rst && (squash || (load_use && !busy && !halt_st));
  assign byp_sel   = byp_q;
  assign halted    = halted_q;

  always_comb begin
    fsm_d       = fsm_q;
    mc_cnt_d    = mc_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stg_d       = stg_q;
    byp_d       = '0;
    halted_d    = halted_q;

    ent_new.valid = 1'b1;
    ent_new.we    = id_we;
    ent_new.dst   = SHD_AW'(id_dst);
    ent_new.load  = id_load;
    ent_new.hlt   = id_hlt;

    if (flow_change) flush_cnt_d = FL_W'(FLUSH_DEPTH - 1);
    else if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - FL_W'(1);

    // While EX is held, stage 0 keeps the multi-cycle op and stage 1 gets a bubble.
    if (busy) stg_d[0] = stg_q[0];
    else      stg_d[0] = issue ? ent_new : SHD_BUBBLE;
    for (int k = 1; k < FWD_STG; k++) begin
      stg_d[k] = (busy && k == 1) ? SHD_BUBBLE : stg_q[k-1];
    end

    if (issue) begin
      for (int p = 0; p < NUM_RD; p++) byp_d[p*FWD_STG +: FWD_STG] = sel[p];
    end

    halted_d = halted_q || (stg_q[FWD_STG-1].valid && stg_q[FWD_STG-1].hlt);

    case (fsm_q)
      ST_RUN: begin
        if (issue && id_hlt) begin
          fsm_d = ST_HALT;
        end else if (issue && id_mc) begin
          fsm_d    = ST_MC_BUSY;
          mc_cnt_d = MC_W'(MC_LAT - 1);
        end
      end
      ST_MC_BUSY: begin
        if (mc_cnt_q == '0) fsm_d = ST_RUN;
        else                mc_cnt_d = mc_cnt_q - MC_W'(1);
      end
      ST_HALT: fsm_d = ST_HALT;
      default: fsm_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_RUN;
      mc_cnt_q    <= '0;
      flush_cnt_q <= '0;
      stg_q       <= '0;
      byp_q       <= '0;
      halted_q    <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      mc_cnt_q    <= mc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stg_q       <= stg_d;
      byp_q       <= byp_d;
      halted_q    <= halted_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios plus random traffic, checked
// against a timestamp-based model of where each issued instruction sits.
module tb_id_hazard_ctrl;

  localparam int unsigned NUM_RD      = 2;
  localparam int unsigned REG_AW      = 4;
  localparam int unsigned FWD_STG     = 2;
  localparam int unsigned MC_LAT      = 3;
  localparam int unsigned FLUSH_DEPTH = 2;
  localparam int          FS          = int'(FWD_STG);
  localparam int          ML          = int'(MC_LAT);
  localparam int          FD          = int'(FLUSH_DEPTH);

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       id_valid = 1'b0;
  logic [NUM_RD-1:0]          id_re = '0;
  logic [NUM_RD*REG_AW-1:0]   id_rd_addr = '0;
  logic                       id_we = 1'b0;
  logic [REG_AW-1:0]          id_dst = '0;
  logic                       id_load = 1'b0;
  logic                       id_mc = 1'b0;
  logic                       id_hlt = 1'b0;
  logic                       flow_change = 1'b0;
  logic                       stall_if, bubble_ex, hold_ex, halted;
  logic [NUM_RD*FWD_STG-1:0]  byp_sel;

  always #5 clk = ~clk;

  id_hazard_ctrl #(
    .NUM_RD(NUM_RD), .REG_AW(REG_AW), .FWD_STG(FWD_STG),
    .MC_LAT(MC_LAT), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_re(id_re),
    .id_rd_addr(id_rd_addr), .id_we(id_we), .id_dst(id_dst),
    .id_load(id_load), .id_mc(id_mc), .id_hlt(id_hlt),
    .flow_change(flow_change), .stall_if(stall_if), .bubble_ex(bubble_ex),
    .hold_ex(hold_ex), .byp_sel(byp_sel), .halted(halted)
  );

  // An issued instruction occupies EX from issue+1 for exlen cycles, then
  // advances one stage per cycle.
  typedef struct {
    int              issue;
    int              exlen;
    logic            we;
    logic [REG_AW-1:0] dst;
    logic            load;
    logic            mc;
  } inst_t;

  inst_t q[$];
  int  cyc = 0;
  bit  flow_seen = 0;
  int  last_flow = 0;
  bit  hlt_seen = 0;
  int  hlt_cyc = 0;
  logic [NUM_RD*FWD_STG-1:0] byp_exp = '0;
  int  checks = 0;
  int  failures = 0;
  logic last_stall, last_bubble, last_hold, last_halted;
  logic [NUM_RD*FWD_STG-1:0] last_byp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int stage_of(input inst_t e, input int c);
    int d;
    if (c >= e.issue + 1 && c <= e.issue + e.exlen) return 0;
    d = c - (e.issue + e.exlen);
    if (d >= 1 && d <= FS - 1) return d;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    flow_seen = 0;
    hlt_seen  = 0;
    byp_exp   = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1; id_valid = 1'b1; flow_change = 1'b1; id_re = '1;
    id_load = 1'b1; id_mc = 1'b1;
    #1;
    chk("rst_stall_if", stall_if, 0);
    chk("rst_bubble_ex", bubble_ex, 0);
    chk("rst_hold_ex", hold_ex, 0);
    chk("rst_byp_sel", byp_sel, 0);
    chk("rst_halted", halted, 0);
    @(posedge clk);
    #2;
    id_valid = 1'b0; flow_change = 1'b0; id_re = '0; id_load = 1'b0; id_mc = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic v, input logic [NUM_RD-1:0] re,
                       input logic [REG_AW-1:0] a0, input logic [REG_AW-1:0] a1,
                       input logic we, input logic [REG_AW-1:0] dst,
                       input logic ld, input logic mc, input logic hlt, input logic fc);
    bit busy, hst, squash, lu, stall_e, bubble_e, issue;
    logic [NUM_RD*FWD_STG-1:0] byp_new;
    logic [NUM_RD-1:0] re_eff;
    logic [REG_AW-1:0] ra [NUM_RD];
    int best, s;
    inst_t e;

    busy = 0;
    foreach (q[i]) if (q[i].mc && cyc >= q[i].issue + 1 && cyc <= q[i].issue + ML) busy = 1;
    hst = hlt_seen && (cyc > hlt_cyc);
    if (busy || hst) fc = 1'b0;
    re_eff = v ? re : '0;

    @(negedge clk);
    id_valid = v; id_re = re_eff; id_rd_addr = {a1, a0}; id_we = we; id_dst = dst;
    id_load = ld; id_mc = mc; id_hlt = hlt; flow_change = fc;
    #1;

    squash = fc || (flow_seen && (cyc - last_flow) < FD);
    ra[0] = a0; ra[1] = a1;
    lu = 0;
    byp_new = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      best = -1;
      foreach (q[i]) begin
        s = stage_of(q[i], cyc);
        if (s >= 0 && re_eff[p] && ra[p] != '0 && q[i].we && q[i].dst == ra[p]) begin
          if (s == 0 && q[i].load) lu = 1;
          else if (best < 0 || s < best) best = s;
        end
      end
      if (best >= 0) byp_new[p*FS + best] = 1'b1;
    end
    stall_e  = !squash && (hst || busy || lu);
    bubble_e = squash || (lu && !busy && !hst);
    issue    = v && !stall_e && !squash && !busy && !hst;

    chk("stall_if", stall_if, stall_e);
    chk("bubble_ex", bubble_ex, bubble_e);
    chk("hold_ex", hold_ex, busy);
    chk("byp_sel", byp_sel, byp_exp);
    chk("halted", halted, hlt_seen && (cyc >= hlt_cyc + FS + 1));
    last_stall = stall_if; last_bubble = bubble_ex; last_hold = hold_ex;
    last_halted = halted; last_byp = byp_sel;

    if (issue) begin
      e.issue = cyc;
      e.exlen = (mc && !hlt) ? ML + 1 : 1;
      e.we = we; e.dst = dst; e.load = ld; e.mc = mc && !hlt;
      q.push_back(e);
      if (hlt) begin hlt_seen = 1; hlt_cyc = cyc; end
    end
    byp_exp = issue ? byp_new : '0;
    if (fc) begin flow_seen = 1; last_flow = cyc; end
    cyc++;
    while (q.size() > 0 && cyc > q[0].issue + q[0].exlen + FS) void'(q.pop_front());
  endtask

  initial begin
    int h, b;
    logic v, we, ld, mc, hlt, fc;
    logic [NUM_RD-1:0] re;
    logic [REG_AW-1:0] a0, a1, dst;

    do_reset();

    // Back-to-back ALU dependency: forwarded from DM, no stall.
    cycle(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 0);
    cycle(1, 2'b11, 3, 1, 1, 4, 0, 0, 0, 0);
    chk("alu_no_stall", last_stall, 0);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_byp", last_byp, 4'b0001);

    // Load-use: one stall cycle, then forwarded from the stage after DM.
    cycle(1, 2'b00, 0, 0, 1, 5, 1, 0, 0, 0);
    cycle(1, 2'b11, 5, 2, 1, 6, 0, 0, 0, 0);
    chk("lu_stall", last_stall, 1);
    chk("lu_bubble", last_bubble, 1);
    cycle(1, 2'b11, 5, 2, 1, 6, 0, 0, 0, 0);
    chk("lu_released", last_stall, 0);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_byp", last_byp, 4'b0010);

    // Writes to R0 never forward.
    cycle(1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 2'b11, 0, 0, 1, 1, 0, 0, 0, 0);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_byp", last_byp, 4'b0000);

    // Multi-cycle op holds EX, then the consumer forwards from DM.
    cycle(1, 2'b00, 0, 0, 1, 7, 0, 1, 0, 0);
    h = 0;
    repeat (4) begin
      cycle(1, 2'b01, 7, 0, 1, 8, 0, 0, 0, 0);
      if (last_hold === 1'b1) h++;
    end
    chk("mc_hold_cycles", h, 3);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mc_byp", last_byp, 4'b0001);

    // Single flow change squashes two cycles.
    b = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 2'b00, 0, 0, 1, 9, 0, 0, 0, (k == 0));
      if (last_bubble === 1'b1) b++;
    end
    chk("flush_bubbles", b, 2);

    // A second flow change mid-count reloads the window.
    b = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 2'b00, 0, 0, 1, 9, 0, 0, 0, (k < 2));
      if (last_bubble === 1'b1) b++;
    end
    chk("reflush_bubbles", b, 3);

    // HLT inside a flush window is discarded.
    cycle(1, 2'b00, 0, 0, 1, 9, 0, 0, 0, 1);
    cycle(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hlt_squashed", last_halted, 0);
    chk("hlt_squashed_stall", last_stall, 0);

    // HLT issue: permanent stall, halted three cycles later.
    cycle(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0);
    chk("hlt_stall", last_stall, 1);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hlt_not_yet", last_halted, 0);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hlt_halted", last_halted, 1);
    repeat (3) cycle(1, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0);
    chk("hlt_sticky_stall", last_stall, 1);

    // Reset in the middle of a multi-cycle hold, then normal issue.
    do_reset();
    cycle(1, 2'b00, 0, 0, 1, 7, 0, 1, 0, 0);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mc_busy_before_rst", last_hold, 1);
    do_reset();
    cycle(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 0);
    chk("post_rst_issue", last_stall, 0);
    cycle(1, 2'b01, 3, 0, 1, 4, 0, 0, 0, 0);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_byp", last_byp, 4'b0001);

    // Random traffic over a small register window for dense hazards.
    repeat (5) begin
      do_reset();
      repeat (300) begin
        v   = ($urandom_range(0, 9) < 8);
        re  = NUM_RD'($urandom);
        a0  = REG_AW'($urandom_range(0, 4));
        a1  = REG_AW'($urandom_range(0, 4));
        we  = ($urandom_range(0, 9) < 8);
        dst = REG_AW'($urandom_range(0, 4));
        ld  = ($urandom_range(0, 3) == 0);
        mc  = !ld && ($urandom_range(0, 11) == 0);
        hlt = !mc && ($urandom_range(0, 199) == 0);
        fc  = ($urandom_range(0, 11) == 0);
        cycle(v, re, a0, a1, we, dst, ld, mc, hlt, fc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
